press_pulse_gen: RTL and testbench

//   Converts a raw, bouncing, asynchronous push-button input into clean

---
 rtl/press_pulse_gen.sv | 149 ++++++++++++++
 tb/tb_press_pulse_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/press_pulse_gen.sv
// rtl/press_pulse_gen.sv - push-button synchronizer, debouncer and press/double/long pulse generator
module press_pulse_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int LONG_CYCLES     = 32,
    parameter int DBL_WINDOW      = 20,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press,
    output logic dbl_press,
    output logic long_press
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HELD  = 3'd1;
    localparam logic [2:0] S_LONG  = 3'd2;
    localparam logic [2:0] S_WAIT2 = 3'd3;
    localparam logic [2:0] S_HELD2 = 3'd4;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_WINDOW - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   btn_level_q, btn_level_d;
    logic                   btn_level_dly_q, btn_level_dly_d;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   press_q, press_d;
    logic                   dbl_q, dbl_d;
    logic                   long_q, long_d;

    logic btn_s;
    logic rise;
    logic fall;

    assign btn_s = sync_q[SYNC_STAGES-1];
    assign rise  = btn_level_q & ~btn_level_dly_q;
    assign fall  = ~btn_level_q & btn_level_dly_q;

    always_comb begin
        sync_d          = {sync_q[SYNC_STAGES-2:0], btn_raw};
        btn_level_d     = btn_level_q;
        btn_level_dly_d = btn_level_q;
        deb_cnt_d       = '0;
        if (btn_s != btn_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_level_d = btn_s;
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counters are cleared whenever the state changes so each state starts its own count.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        press_d    = 1'b0;
        dbl_d      = 1'b0;
        long_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_HELD;
                    press_d = 1'b1;
                end
            end
            S_HELD: begin
                if (hold_cnt_q == LONG_LAST) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                end else if (fall) begin
                    state_d = S_WAIT2;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            S_LONG: begin
                // Level rather than edge, so a release coinciding with the long qualification still exits.
                if (!btn_level_q) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT2: begin
                if (rise) begin
                    state_d = S_HELD2;
                    press_d = 1'b1;
                    dbl_d   = 1'b1;
                end else if (gap_cnt_q == DBL_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_W'(1);
                end
            end
            S_HELD2: begin
                if (fall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            hold_cnt_d = '0;
            gap_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q          <= '0;
            deb_cnt_q       <= '0;
            btn_level_q     <= 1'b0;
            btn_level_dly_q <= 1'b0;
            state_q         <= S_IDLE;
            hold_cnt_q      <= '0;
            gap_cnt_q       <= '0;
            press_q         <= 1'b0;
            dbl_q           <= 1'b0;
            long_q          <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            deb_cnt_q       <= deb_cnt_d;
            btn_level_q     <= btn_level_d;
            btn_level_dly_q <= btn_level_dly_d;
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            press_q         <= press_d;
            dbl_q           <= dbl_d;
            long_q          <= long_d;
        end
    end

    assign btn_level  = btn_level_q;
    assign press      = press_q;
    assign dbl_press  = dbl_q;
    assign long_press = long_q;

endmodule

// File: tb/tb_press_pulse_gen.sv
// tb/tb_press_pulse_gen.sv - scoreboard bench for press_pulse_gen against an event-timeline model
module tb_press_pulse_gen;

    localparam int SYNC  = 2;
    localparam int DEB   = 8;
    localparam int LONGC = 32;
    localparam int DBLW  = 20;
    localparam int MAXN  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic btn_level, press, dbl_press, long_press;

    press_pulse_gen #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONGC),
        .DBL_WINDOW(DBLW), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
        .press(press), .dbl_press(dbl_press), .long_press(long_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] ev;
    } exp_t;

    exp_t exp_q[$];
    bit   stim[0:MAXN-1];
    bit   exp_lvl[0:MAXN-1];
    int   stim_n  = 0;
    int   drive_k = -1;
    int   checks  = 0;
    int   errors  = 0;

    function automatic bit s_at(int j);
        return (j >= SYNC) ? stim[j-SYNC] : 1'b0;
    endfunction

    task automatic add_run(input bit v, input int len);
        for (int i = 0; i < len; i++) begin
            if (stim_n < MAXN) begin
                stim[stim_n] = v;
                stim_n++;
            end
        end
    endtask

    task automatic push_ev(input int cyc, input logic [2:0] ev, input int lim);
        exp_t e;
        if (cyc < lim) begin
            e.cyc = cyc;
            e.ev  = ev;
            exp_q.push_back(e);
        end
    endtask

    // Level follows the synchronized input once DEB consecutive samples disagree with it;
    // pulses are derived from the resulting rise/fall timeline.
    task automatic build_model(input int lim);
        bit lvl;
        bit all_diff;
        int rises[$];
        int falls[$];
        int i, r, f;
        lvl = 1'b0;
        for (int k = 0; k < stim_n; k++) begin
            all_diff = 1'b1;
            for (int d = 0; d < DEB; d++) begin
                if (s_at(k - d) == lvl) all_diff = 1'b0;
            end
            if (all_diff) begin
                lvl = ~lvl;
                if (lvl) rises.push_back(k);
                else     falls.push_back(k);
            end
            exp_lvl[k] = lvl;
        end
        i = 0;
        while (i < rises.size()) begin
            r = rises[i];
            f = (i < falls.size()) ? falls[i] : (1 << 30);
            push_ev(r + 1, 3'b001, lim);
            if (f - r >= LONGC) begin
                push_ev(r + 1 + LONGC, 3'b100, lim);
                i++;
            end else if (i + 1 < rises.size() && rises[i+1] - f <= DBLW) begin
                push_ev(rises[i+1] + 1, 3'b011, lim);
                i += 2;
            end else begin
                i++;
            end
        end
    endtask

    task automatic run_seg(input int cut);
        int  lim;
        bit  broke;
        lim   = (cut < stim_n) ? cut : stim_n;
        broke = 1'b0;
        build_model(lim);
        for (int k = 0; k < stim_n; k++) begin
            @(negedge clk);
            if (k == cut) begin
                broke = 1'b1;
                break;
            end
            rst     = 1'b0;
            btn_raw = stim[k];
            drive_k = k;
        end
        if (!broke) @(negedge clk);
        rst     = 1'b1;
        drive_k = -1;
        repeat (2) begin
            btn_raw = 1'($urandom);
            @(negedge clk);
        end
        btn_raw = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected pulses never seen, first at cycle %0d",
                     exp_q.size(), exp_q[0].cyc);
        end
        exp_q.delete();
        stim_n = 0;
    endtask

    task automatic rand_stim(input int n);
        bit v;
        int len;
        v = 1'($urandom);
        while (stim_n < n) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 45);
            if (stim_n + len > n) len = n - stim_n;
            add_run(v, len);
            v = ~v;
        end
    endtask

    initial begin : monitor
        int         k;
        logic [2:0] got;
        exp_t       e;
        forever begin
            @(posedge clk);
            #1;
            got = {long_press, dbl_press, press};
            k   = drive_k;
            if (k < 0) begin
                checks++;
                if (got !== 3'b000 || btn_level !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_outputs: got pulses=%b level=%b, required 000 and 0",
                             got, btn_level);
                end
            end else begin
                checks++;
                if (btn_level !== exp_lvl[k]) begin
                    errors++;
                    $display("FAIL btn_level cycle %0d: got %b, required %b", k, btn_level, exp_lvl[k]);
                end
                while (exp_q.size() != 0 && exp_q[0].cyc < k) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_pulse cycle %0d: got none, required {long,dbl,press}=%b",
                             e.cyc, e.ev);
                end
                if (got !== 3'b000) begin
                    checks++;
                    if (exp_q.size() == 0 || exp_q[0].cyc != k) begin
                        errors++;
                        $display("FAIL spurious_pulse cycle %0d: got {long,dbl,press}=%b, required 000",
                                 k, got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e.ev) begin
                            errors++;
                            $display("FAIL pulse cycle %0d: got {long,dbl,press}=%b, required %b",
                                     k, got, e.ev);
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        repeat (2) begin
            btn_raw = 1'($urandom);
            @(negedge clk);
        end
        btn_raw = 1'b0;

        add_run(1, 15); add_run(0, 45); run_seg(MAXN);

        for (int i = 0; i < 10; i++) add_run(((i % 2) == 0), 3);
        add_run(1, 60); add_run(0, 30); run_seg(MAXN);

        add_run(1, 12); add_run(0, 12); add_run(1, 12); add_run(0, 40); run_seg(MAXN);

        add_run(1, 12); add_run(0, 40); add_run(1, 12); add_run(0, 40); run_seg(MAXN);

        add_run(1, 60); add_run(0, 10); add_run(1, 15); add_run(0, 40); run_seg(MAXN);

        add_run(1, 12); add_run(0, 20); add_run(1, 12); add_run(0, 40); run_seg(MAXN);
        add_run(1, 12); add_run(0, 21); add_run(1, 12); add_run(0, 40); run_seg(MAXN);

        add_run(1, 32); add_run(0, 50); run_seg(MAXN);
        add_run(1, 31); add_run(0, 50); run_seg(MAXN);

        add_run(1, 40); add_run(0, 20); run_seg(25);
        add_run(1, 50); add_run(0, 20); run_seg(30);

        for (int s = 0; s < 8; s++) begin
            rand_stim(300);
            run_seg(($urandom_range(0, 2) == 0) ? $urandom_range(20, 299) : MAXN);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
